fetch_ctrl: RTL and testbench

Sequencing controller for the instruction-fetch PC register. Arbitrates redirect sources (trap/interrupt vector, execute-stage branch/jump), memory stalls and debug halt, and drives the fetch stage's `hold`, `jump_flag` and `jump_addr` inputs. It also produces a `flush` strobe that squashes wrong-path instructions in decode/execute. It sits between the execute/CSR logic and the PC register and is the only driver of those three fetch inputs.

---
 rtl/fetch_ctrl_pkg.sv | 29 ++
 rtl/fetch_ctrl_redirect_arb.sv | 100 ++++++++++
 rtl/fetch_ctrl.sv | 127 ++++++++++++
 tb/tb_fetch_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg
// Shared definitions for the fetch sequencing controller: FSM state codes,
// redirect source IDs and default parameter values.
// The PC/redirect width follows the global `InstCatchDepth define. If no
// global define is visible, a 32-bit fallback is used.

`ifndef InstCatchDepth
`define InstCatchDepth 32
`endif

package fetch_ctrl_pkg;

  localparam int unsigned ADDR_W_DEF       = `InstCatchDepth;
  localparam int unsigned FLUSH_CYCLES_DEF = 2;
  localparam int unsigned FLUSH_CNT_W      = 4;  // enough for FLUSH_CYCLES up to 15

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } fc_state_e;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_EX   = 2'd1,
    SRC_TRAP = 2'd2
  } src_id_e;

endpackage

// File: rtl/fetch_ctrl_redirect_arb.sv
// fetch_ctrl_redirect_arb
// Redirect arbitration for fetch_ctrl. It picks the winning incoming request
// (trap over execute-stage jump) and keeps one pending redirect that is
// captured while memory is stalled. The pending redirect wins over anything
// incoming, and it is cleared on the first unstalled cycle, which is the
// cycle it issues.
//
// Ports
//   clk, rst          clock, async active-high reset
//   trap_en_i         trap requests are accepted (not halted)
//   ex_en_i           execute jumps are accepted (plain RUN only)
//   trap_req_i/vec_i  trap request and handler address
//   ex_jump_req_i     execute-stage taken branch/jump
//   ex_jump_addr_i    its target
//   mem_stall_i       memory stall / hazard
//   cand_valid_o      a redirect is ready to issue or waiting on the stall
//   cand_src_o        source of the candidate (SRC_EX / SRC_TRAP)
//   cand_addr_o       candidate target address

module fetch_ctrl_redirect_arb
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trap_en_i,
  input  logic              ex_en_i,
  input  logic              trap_req_i,
  input  logic [ADDR_W-1:0] trap_vec_i,
  input  logic              ex_jump_req_i,
  input  logic [ADDR_W-1:0] ex_jump_addr_i,
  input  logic              mem_stall_i,
  output logic              cand_valid_o,
  output src_id_e           cand_src_o,
  output logic [ADDR_W-1:0] cand_addr_o
);

  src_id_e           pend_src_q, pend_src_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  src_id_e           in_src;
  logic [ADDR_W-1:0] in_addr;

  // Incoming winner, trap first.
  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    in_src  = SRC_NONE;
    in_addr = '0;
    if (trap_req_i && trap_en_i) begin
      in_src  = SRC_TRAP;
      in_addr = trap_vec_i;
    end else if (ex_jump_req_i && ex_en_i) begin
      in_src  = SRC_EX;
      in_addr = ex_jump_addr_i;
    end
  end

  // A pending redirect always takes precedence over what arrives this cycle.
  always_comb begin
    if (pend_src_q != SRC_NONE) begin
      cand_src_o  = pend_src_q;
      cand_addr_o = pend_addr_q;
    end else begin
      cand_src_o  = in_src;
      cand_addr_o = in_addr;
    end
    cand_valid_o = (cand_src_o != SRC_NONE);
  end

  always_comb begin
    pend_src_d  = pend_src_q;
    pend_addr_d = pend_addr_q;
    if (!mem_stall_i) begin
      // Unstalled: whatever was pending issues now, so the slot empties.
      pend_src_d  = SRC_NONE;
      pend_addr_d = '0;
    end else if (in_src == SRC_TRAP && pend_src_q != SRC_TRAP) begin
      // A trap replaces a waiting execute jump; that jump was wrong-path.
      pend_src_d  = SRC_TRAP;
      pend_addr_d = in_addr;
    end else if (in_src == SRC_EX && pend_src_q == SRC_NONE) begin
      pend_src_d  = SRC_EX;
      pend_addr_d = in_addr;
    end
  end

  // NOTE: the pending redirect is real control state, so it is cleared by the
  // async reset; a stale target must never survive a reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_src_q  <= SRC_NONE;
      pend_addr_q <= '0;
    end else begin
      pend_src_q  <= pend_src_d;
      pend_addr_q <= pend_addr_d;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl
// Sequencing controller for the instruction-fetch PC register. It is the
// only driver of the fetch stage's hold / jump_flag / jump_addr. It also
// produces the flush strobe that squashes wrong-path decode/execute contents.
//
// Ports
//   clk, rst       clock, async active-high reset
//   ex_jump_req    execute stage resolved a taken branch/jump
//   ex_jump_addr   its target
//   trap_req       interrupt/exception; held by the requester until trap_ack
//   trap_vec       trap handler address
//   mem_stall      memory not ready or load-use hazard
//   halt_req       debug halt request (level)
//   resume_req     debug resume (single-cycle pulse)
//   hold           freeze PC
//   jump_flag      load jump_addr into PC this edge
//   jump_addr      redirect target (0 when jump_flag is low)
//   flush          invalidate decode/execute contents
//   trap_ack       trap redirect issued this cycle
//   halted         core is in debug halt
//
// FLUSH_CYCLES must be in 1..15. The issue cycle is the first flush cycle,
// so the FLUSH state lasts FLUSH_CYCLES-1 advancing cycles after it.

module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_jump_req,
  input  logic [ADDR_W-1:0] ex_jump_addr,
  input  logic              trap_req,
  input  logic [ADDR_W-1:0] trap_vec,
  input  logic              mem_stall,
  input  logic              halt_req,
  input  logic              resume_req,
  output logic              hold,
  output logic              jump_flag,
  output logic [ADDR_W-1:0] jump_addr,
  output logic              flush,
  output logic              trap_ack,
  output logic              halted
);

  localparam logic [FLUSH_CNT_W-1:0] CNT_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

  fc_state_e              state_q;
  logic [FLUSH_CNT_W-1:0] cnt_q;      // FLUSH cycles left, including the current one
  logic                   cand_valid;
  src_id_e                cand_src;
  logic [ADDR_W-1:0]      cand_addr;
  logic                   issue;

  // Execute jumps are wrong-path while flushing; nothing is taken in HALT.
  fetch_ctrl_redirect_arb #(.ADDR_W(ADDR_W)) u_redirect_arb (
    .clk            (clk),
    .rst            (rst),
    .trap_en_i      (state_q != ST_HALT),
    .ex_en_i        (state_q == ST_RUN),
    .trap_req_i     (trap_req),
    .trap_vec_i     (trap_vec),
    .ex_jump_req_i  (ex_jump_req),
    .ex_jump_addr_i (ex_jump_addr),
    .mem_stall_i    (mem_stall),
    .cand_valid_o   (cand_valid),
    .cand_src_o     (cand_src),
    .cand_addr_o    (cand_addr)
  );

  // Redirect outputs are combinational from inputs. They are gated by rst
  // so that all outputs fall to 0 the moment reset asserts, even while a
  // trap or stall is still being driven.
  assign issue = cand_valid && !mem_stall && !rst;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else if (issue) begin
      // Issue from RUN, or a trap in FLUSH: (re)start the flush window.
      if (FLUSH_CYCLES > 1) begin
        state_q <= ST_FLUSH;
        cnt_q   <= CNT_LOAD;
      end else begin
        state_q <= ST_RUN;
        cnt_q   <= '0;
      end
    end else begin
      case (state_q)
        ST_RUN: begin
          if (halt_req && !cand_valid && !mem_stall) state_q <= ST_HALT;
        end
        ST_FLUSH: begin
          // Stalled cycles do not advance, which stretches the flush pulse.
          if (!mem_stall) begin
            if (cnt_q <= 1) begin
              state_q <= ST_RUN;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
        end
        ST_HALT: begin
          if (resume_req) state_q <= ST_RUN;
        end
        default: begin
          state_q <= ST_RUN;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign hold      = !rst && (mem_stall || state_q == ST_HALT);
  assign jump_flag = issue;
  assign jump_addr = issue ? cand_addr : '0;
  assign trap_ack  = issue && (cand_src == SRC_TRAP);
  assign flush     = issue || (state_q == ST_FLUSH);
  assign halted    = (state_q == ST_HALT);

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl
// Scoreboard bench for fetch_ctrl. The driver applies one cycle of stimulus
// and evaluates a behavioural model of the sequencing rules. It pushes the
// expected per-cycle status, and any expected redirect, into queues. A monitor
// on the falling edge pops and compares against what the DUT presents.

module tb_fetch_ctrl;

  localparam int AW = 32;
  localparam int FC = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          ex_jump_req, trap_req, mem_stall, halt_req, resume_req;
  logic [AW-1:0] ex_jump_addr, trap_vec;
  logic          hold, jump_flag, flush, trap_ack, halted;
  logic [AW-1:0] jump_addr;

  always #5 clk = ~clk;

  fetch_ctrl #(.ADDR_W(AW), .FLUSH_CYCLES(FC)) dut (
    .clk          (clk),
    .rst          (rst),
    .ex_jump_req  (ex_jump_req),
    .ex_jump_addr (ex_jump_addr),
    .trap_req     (trap_req),
    .trap_vec     (trap_vec),
    .mem_stall    (mem_stall),
    .halt_req     (halt_req),
    .resume_req   (resume_req),
    .hold         (hold),
    .jump_flag    (jump_flag),
    .jump_addr    (jump_addr),
    .flush        (flush),
    .trap_ack     (trap_ack),
    .halted       (halted)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic hold, flush, halted, ack, jf;
    int   cyc;
  } status_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic          is_trap;
    int            cyc;
  } jump_t;

  status_t st_q[$];
  jump_t   jmp_q[$];
  int      cyc = 0;

  // Behavioural model: halted flag, count of flush cycles still to come,
  // and one waiting redirect.
  bit            m_halted;
  int            m_flush_left;
  bit            m_pv, m_pt;
  logic [AW-1:0] m_pa;
  // Trap requester: holds the request until the model says it was taken.
  bit            trap_hold;
  logic [AW-1:0] trap_vec_hold;

  task automatic model_reset();
    m_halted = 0; m_flush_left = 0; m_pv = 0; m_pt = 0; m_pa = '0;
    trap_hold = 0; trap_vec_hold = '0;
  endtask

  // One cycle: called just after a rising edge, returns just after the next.
  task automatic step(input bit ex, input logic [AW-1:0] exa, input bit trap,
                      input logic [AW-1:0] vec, input bit stall, input bit halt,
                      input bit resume);
    bit in_fl, t_ok, e_ok, cv, ct, iss;
    logic [AW-1:0] ca;
    status_t s;
    jump_t j;
    if (trap && !trap_hold) begin
      trap_hold = 1; trap_vec_hold = vec;
    end
    ex_jump_req  = ex;
    ex_jump_addr = exa;
    trap_req     = trap_hold;
    trap_vec     = trap_hold ? trap_vec_hold : AW'($urandom);
    mem_stall    = stall;
    halt_req     = halt;
    resume_req   = resume;

    in_fl = (m_flush_left > 0);
    t_ok  = trap_hold && !m_halted;
    e_ok  = ex && !m_halted && !in_fl;
    cv = 1; ct = 0; ca = '0;
    if (m_pv)      begin ct = m_pt; ca = m_pa; end
    else if (t_ok) begin ct = 1;    ca = trap_vec_hold; end
    else if (e_ok) begin ct = 0;    ca = exa; end
    else cv = 0;
    iss = cv && !stall;

    s.hold = m_halted || stall; s.flush = iss || in_fl; s.halted = m_halted;
    s.ack = iss && ct; s.jf = iss; s.cyc = cyc;
    st_q.push_back(s);
    if (iss) begin
      j.addr = ca; j.is_trap = ct; j.cyc = cyc;
      jmp_q.push_back(j);
    end

    if (m_halted) begin
      if (resume) m_halted = 0;
    end else if (iss) begin
      m_flush_left = FC - 1;
      m_pv = 0;
      if (ct) trap_hold = 0;
    end else if (stall) begin
      if (t_ok && !(m_pv && m_pt)) begin m_pv = 1; m_pt = 1; m_pa = trap_vec_hold; end
      else if (e_ok && !m_pv)      begin m_pv = 1; m_pt = 0; m_pa = exa; end
    end else if (in_fl) begin
      m_flush_left--;
    end else if (halt && !cv) begin
      m_halted = 1;
    end

    cyc++;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, 0, '0, 0, 0, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_hold"},      hold,      0);
    check({tag, "_jump_flag"}, jump_flag, 0);
    check({tag, "_jump_addr"}, jump_addr, 0);
    check({tag, "_flush"},     flush,     0);
    check({tag, "_trap_ack"},  trap_ack,  0);
    check({tag, "_halted"},    halted,    0);
  endtask

  // Asynchronous reset between edges, with whatever inputs are being driven.
  task automatic async_reset();
    @(negedge clk); #2;
    rst = 1;
    #1;
    check_all_zero("async_rst");
    model_reset();
    ex_jump_req = 0; trap_req = 0; mem_stall = 0; halt_req = 0; resume_req = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
  endtask

  // Monitor
  status_t ms;
  jump_t   mj;
  always @(negedge clk) begin
    if (st_q.size() > 0) begin
      ms = st_q.pop_front();
      check("hold",      hold,      ms.hold);
      check("flush",     flush,     ms.flush);
      check("halted",    halted,    ms.halted);
      check("trap_ack",  trap_ack,  ms.ack);
      check("jump_flag", jump_flag, ms.jf);
      if (jump_flag) begin
        check("jump_expected", (jmp_q.size() > 0), 1);
        if (jmp_q.size() > 0) begin
          mj = jmp_q.pop_front();
          check("jump_addr",  jump_addr, mj.addr);
          check("jump_cycle", ms.cyc,    mj.cyc);
          check("jump_src",   trap_ack,  mj.is_trap);
        end
      end else begin
        check("jump_addr_idle", jump_addr, 0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1;
    ex_jump_req = 0; ex_jump_addr = '0; trap_req = 0; trap_vec = '0;
    mem_stall = 0; halt_req = 0; resume_req = 0;
    model_reset();
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 0;
    @(posedge clk); #1;

    // Branch, no stall; a second branch in the flush window is ignored.
    step(1, 32'h40, 0, '0, 0, 0, 0);
    step(1, 32'h44, 0, '0, 0, 0, 0);
    idle(3);

    // Branch captured under a 3-cycle stall, issued on the 4th cycle.
    step(1, 32'h80, 0, '0, 1, 0, 0);
    step(0, '0, 0, '0, 1, 0, 0);
    step(0, '0, 0, '0, 1, 0, 0);
    idle(4);

    // Trap overwrites a pending branch.
    step(1, 32'h80, 0, '0, 1, 0, 0);
    step(0, '0, 1, 32'h10, 1, 0, 0);
    idle(5);

    // Trap in the second flush cycle issues immediately and restarts flush.
    step(1, 32'h200, 0, '0, 0, 0, 0);
    step(0, '0, 1, 32'h10, 0, 0, 0);
    idle(4);

    // Debug halt: trap ignored while halted, issued after resume.
    step(0, '0, 0, '0, 0, 1, 0);
    step(0, '0, 1, 32'h10, 0, 1, 0);
    step(0, '0, 0, '0, 0, 1, 0);
    step(0, '0, 0, '0, 0, 0, 1);
    idle(4);

    // Async reset mid-FLUSH with a trap pending under stall.
    step(1, 32'h300, 0, '0, 0, 0, 0);
    step(0, '0, 1, 32'h20, 1, 0, 0);
    async_reset();
    idle(4);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 9) < 3, AW'($urandom) & 32'hFFFF_FFFC,
           $urandom_range(0, 19) == 0, AW'($urandom) & 32'hFFFF_FFFC,
           $urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0,
           $urandom_range(0, 9) == 0);
      if (i == 1000) async_reset();
    end
    // Drain: let any held trap and flush window complete.
    step(0, '0, 0, '0, 0, 0, 1);
    idle(8);
    @(negedge clk); #1;
    check("jump_queue_drained", jmp_q.size(), 0);
    check("status_queue_drained", st_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
